// File: rtl/leg_packer_if.sv
// Output-side bundle of leg_packer: head word, valid/ready handshake and sticky overflow.
// word_parity exists only when LEG_PACKER_PARITY_EN is defined.
interface leg_packer_if #(
   parameter int W = 16
);
   logic [W-1:0] word_data;
   logic         word_valid;
   logic         word_ready;
   logic         overflow;
`ifdef LEG_PACKER_PARITY_EN
   logic         word_parity;
`endif

   modport master (
`ifdef LEG_PACKER_PARITY_EN
      output word_parity,
`endif
      output word_data,
      output word_valid,
      output overflow,
      input  word_ready
   );

   modport slave (
`ifdef LEG_PACKER_PARITY_EN
      input  word_parity,
`endif
      input  word_data,
      input  word_valid,
      input  overflow,
      output word_ready
   );
endinterface

// File: rtl/leg_packer.sv
// Packs SAMPLES 4-bit leg samples per word into a small FIFO drained over valid/ready.
// Optional macro LEG_PACKER_PARITY_EN adds a stored parity bit per entry and the word_parity output.
module leg_packer #(
   parameter int SAMPLES    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          enable,
   input  logic          leg_right1,
   input  logic          leg_right2,
   input  logic          leg_right3,
   input  logic          leg_right4,
   leg_packer_if.master  out_if
);
   localparam int W  = 4 * SAMPLES;
   localparam int CW = $clog2(SAMPLES);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int NW = PW + 1;
`ifdef LEG_PACKER_PARITY_EN
   localparam int EW = W + 1;
`else
   localparam int EW = W;
`endif
   localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES - 1);
   localparam logic [NW-1:0] CNT_FULL = NW'(FIFO_DEPTH);

   logic [3:0]    nibble;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-5:0]  partial_q, partial_d;
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [EW-1:0] mem_d [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [NW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [W-1:0]  word_new;
   logic [EW-1:0] entry_new;
   logic [EW-1:0] head;
   logic          push, pop, full, push_ok;

   assign nibble = {leg_right4, leg_right3, leg_right2, leg_right1};

   always_comb begin
      word_new = {nibble, partial_q};
`ifdef LEG_PACKER_PARITY_EN
      entry_new = {^word_new, word_new};
`else
      entry_new = word_new;
`endif
      push    = enable && (cnt_q == CNT_LAST);
      pop     = (count_q != '0) && out_if.word_ready;
      full    = (count_q == CNT_FULL);
      // A full FIFO still accepts the new word when the head leaves on the same edge.
      push_ok = push && (!full || pop);

      cnt_d     = cnt_q;
      partial_d = partial_q;
      mem_d     = mem_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;

      if (clear) begin
         cnt_d     = '0;
         partial_d = '0;
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         count_d   = '0;
         ovf_d     = 1'b0;
      end else begin
         if (enable) begin
            if (push) begin
               cnt_d     = '0;
               partial_d = '0;
            end else begin
               partial_d[4*int'(cnt_q) +: 4] = nibble;
               cnt_d = cnt_q + 1'b1;
            end
         end
         if (push_ok) begin
            mem_d[wr_ptr_q] = entry_new;
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (push && !push_ok)
            ovf_d = 1'b1;
         if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         partial_q <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         partial_q <= partial_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
      end
   end

   // Storage needs no reset: outputs are masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head              = mem_q[rd_ptr_q];
   assign out_if.word_valid = (count_q != '0);
   assign out_if.word_data  = out_if.word_valid ? head[W-1:0] : '0;
   assign out_if.overflow   = ovf_q;
`ifdef LEG_PACKER_PARITY_EN
   assign out_if.word_parity = out_if.word_valid ? head[W] : 1'b0;
`endif
endmodule
